approx_mul8_seq_ctrl: RTL and testbench

- Sequencer that builds one 8x8 unsigned product from a single shared, combinational 4x4 multiplier.
- Issues the four nibble products ll, lh, hl and hh over successive cycles and latches them into stable buses.
- Those buses feed the approximate partial-product adder; the controller captures the adder's 16-bit sum and returns it through a valid/ready handshake.
- Sits between the operand source and the 4x4 multiplier / approximate-adder pair, so a single multiplier LUT cluster serves the full 8x8 operation.

---
 rtl/approx_mul8_seq_ctrl_pkg.sv | 25 ++
 rtl/approx_mul8_seq_ctrl_if.sv | 35 +++
 rtl/approx_mul8_seq_ctrl_pp_slot_sel.sv | 32 +++
 rtl/approx_mul8_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_approx_mul8_seq_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mul8_seq_ctrl_pkg.sv
// Shared types and constants for the 8x8 multiply sequencer built around one 4x4 multiplier.
package approx_mul8_seq_ctrl_pkg;

    localparam int unsigned NIB_W     = 4;
    localparam int unsigned PP_W      = 8;
    localparam int unsigned RES_W     = 16;
    localparam int unsigned NUM_SLOTS = 4;

    localparam logic [1:0] SLOT_LL = 2'd0;
    localparam logic [1:0] SLOT_LH = 2'd1;
    localparam logic [1:0] SLOT_HL = 2'd2;
    localparam logic [1:0] SLOT_HH = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StSum,
        StOut
    } state_e;

    function automatic logic [NIB_W-1:0] nib_sel(input logic [PP_W-1:0] v, input logic hi);
        return hi ? v[PP_W-1:NIB_W] : v[NIB_W-1:0];
    endfunction

endpackage

// File: rtl/approx_mul8_seq_ctrl_if.sv
// Operand, multiplier, partial-product, adder and result signals of the sequencer.
interface approx_mul8_seq_ctrl_if;
    import approx_mul8_seq_ctrl_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [PP_W-1:0]  in_a;
    logic [PP_W-1:0]  in_b;
    logic             mul_en;
    logic [NIB_W-1:0] mul_a;
    logic [NIB_W-1:0] mul_b;
    logic [PP_W-1:0]  mul_p;
    logic [PP_W-1:0]  pp_ll;
    logic [PP_W-1:0]  pp_lh;
    logic [PP_W-1:0]  pp_hl;
    logic [PP_W-1:0]  pp_hh;
    logic [RES_W-1:0] sum_in;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_result;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, mul_p, sum_in, out_ready,
        output in_ready, mul_en, mul_a, mul_b, pp_ll, pp_lh, pp_hl, pp_hh,
        output out_valid, out_result, busy
    );

    modport master (
        output in_valid, in_a, in_b, mul_p, sum_in, out_ready,
        input  in_ready, mul_en, mul_a, mul_b, pp_ll, pp_lh, pp_hl, pp_hh,
        input  out_valid, out_result, busy
    );

endinterface

// File: rtl/approx_mul8_seq_ctrl_pp_slot_sel.sv
// Priority encoder: lowest pending slot -> slot index, nibble operands and one-hot write enable.
module approx_mul8_seq_ctrl_pp_slot_sel
    import approx_mul8_seq_ctrl_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] i_mask,
    input  logic [PP_W-1:0]      i_a,
    input  logic [PP_W-1:0]      i_b,
    output logic [1:0]           o_slot,
    output logic [NIB_W-1:0]     o_nib_a,
    output logic [NIB_W-1:0]     o_nib_b,
    output logic [NUM_SLOTS-1:0] o_we
);

    always_comb begin
        o_slot = SLOT_LL;
        o_we   = '0;
        if (i_mask[SLOT_LL]) begin
            o_slot = SLOT_LL;
        end else if (i_mask[SLOT_LH]) begin
            o_slot = SLOT_LH;
        end else if (i_mask[SLOT_HL]) begin
            o_slot = SLOT_HL;
        end else if (i_mask[SLOT_HH]) begin
            o_slot = SLOT_HH;
        end
        o_we[o_slot] = |i_mask;
        // Slot bit 1 picks the high nibble of a, bit 0 the high nibble of b.
        o_nib_a = nib_sel(i_a, o_slot[1]);
        o_nib_b = nib_sel(i_b, o_slot[0]);
    end

endmodule

// File: rtl/approx_mul8_seq_ctrl.sv
// Sequences the four nibble products of an 8x8 multiply through one shared 4x4 multiplier
// and returns the external adder's sum over a valid/ready handshake.
module approx_mul8_seq_ctrl
    import approx_mul8_seq_ctrl_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    approx_mul8_seq_ctrl_if.slave bus
);

    state_e                r_state;
    state_e                w_state_next;
    logic [PP_W-1:0]       r_a;
    logic [PP_W-1:0]       r_b;
    logic [NUM_SLOTS-1:0]  r_mask;
    logic [NUM_SLOTS-1:0]  w_mask_init;
    logic [NUM_SLOTS-1:0]  w_mask_next;
    logic [PP_W-1:0]       r_pp [NUM_SLOTS];
    logic [RES_W-1:0]      r_result;
    logic [1:0]            w_slot;
    logic [NIB_W-1:0]      w_nib_a;
    logic [NIB_W-1:0]      w_nib_b;
    logic [NUM_SLOTS-1:0]  w_we;
    logic                  w_accept;

    approx_mul8_seq_ctrl_pp_slot_sel u_sel (
        .i_mask  (r_mask),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_slot  (w_slot),
        .o_nib_a (w_nib_a),
        .o_nib_b (w_nib_b),
        .o_we    (w_we)
    );

    // A pair with a zero nibble has a zero product, so its multiplier cycle can be dropped.
    always_comb begin
        w_mask_init = '1;
        if (SKIP_ZERO) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (nib_sel(bus.in_a, i[1]) == '0 || nib_sel(bus.in_b, i[0]) == '0) begin
                    w_mask_init[i] = 1'b0;
                end
            end
        end
    end

    assign w_mask_next = r_mask & ~w_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.mul_en    = 1'b0;
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        unique case (r_state)
            StIdle: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = (w_mask_init != '0) ? StMul : StSum;
                end
            end
            StMul: begin
                bus.mul_en = 1'b1;
                bus.mul_a  = w_nib_a;
                bus.mul_b  = w_nib_b;
                if (w_mask_next == '0) begin
                    w_state_next = StSum;
                end
            end
            StSum: begin
                w_state_next = StOut;
            end
            StOut: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mask   <= '0;
            r_result <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_pp[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_a    <= bus.in_a;
                r_b    <= bus.in_b;
                r_mask <= w_mask_init;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    r_pp[i] <= '0;
                end
            end
            if (r_state == StMul) begin
                r_pp[w_slot] <= bus.mul_p;
                r_mask       <= w_mask_next;
            end
            if (r_state == StSum) begin
                r_result <= bus.sum_in;
            end
        end
    end

    assign bus.pp_ll      = r_pp[SLOT_LL];
    assign bus.pp_lh      = r_pp[SLOT_LH];
    assign bus.pp_hl      = r_pp[SLOT_HL];
    assign bus.pp_hh      = r_pp[SLOT_HH];
    assign bus.out_result = r_result;

endmodule

// File: tb/tb_approx_mul8_seq_ctrl.sv
// Runs SKIP_ZERO=0 and SKIP_ZERO=1 controllers side by side on shared stimulus and checks
// both against an arithmetic model of the nibble products, issue order and timing.
module tb_approx_mul8_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_in_valid;
    logic       d_out_ready;
    logic [7:0] d_in_a;
    logic [7:0] d_in_b;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    bit          bb_mode = 1'b0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slots in issue order: 0=ll, 1=lh, 2=hl, 3=hh.
    function automatic int nib_of(input logic [7:0] v, input bit hi);
        return hi ? int'(v) / 16 : int'(v) % 16;
    endfunction

    function automatic int slot_prod(input logic [7:0] a, input logic [7:0] b, input int s);
        return nib_of(a, s >= 2) * nib_of(b, s % 2 == 1);
    endfunction

    function automatic bit slot_runs(input bit skip, input logic [7:0] a, input logic [7:0] b,
                                     input int s);
        return !skip || slot_prod(a, b, s) != 0;
    endfunction

    function automatic int n_mul(input bit skip, input logic [7:0] a, input logic [7:0] b);
        int cnt = 0;
        for (int s = 0; s < 4; s++) if (slot_runs(skip, a, b, s)) cnt++;
        return cnt;
    endfunction

    function automatic int kth_slot(input bit skip, input logic [7:0] a, input logic [7:0] b,
                                    input int k);
        int cnt = 0;
        for (int s = 0; s < 4; s++) begin
            if (slot_runs(skip, a, b, s)) begin
                if (cnt == k) return s;
                cnt++;
            end
        end
        return 0;
    endfunction

    // Approximate adder stand-in: middle partial products merged with OR instead of a sum.
    function automatic int adder_model(input int ll, input int lh, input int hl, input int hh);
        return ll + ((lh | hl) << 4) + (hh << 8);
    endfunction

    function automatic int model_result(input logic [7:0] a, input logic [7:0] b);
        return adder_model(slot_prod(a, b, 0), slot_prod(a, b, 1), slot_prod(a, b, 2),
                           slot_prod(a, b, 3));
    endfunction

    function automatic logic [7:0] rnd_byte();
        logic [3:0] h;
        logic [3:0] l;
        h = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
        l = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
        return {h, l};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit Skip = (g == 1);
        int unsigned done_cnt;

        approx_mul8_seq_ctrl_if bus ();

        assign bus.in_valid  = d_in_valid;
        assign bus.in_a      = d_in_a;
        assign bus.in_b      = d_in_b;
        assign bus.out_ready = d_out_ready;
        assign bus.mul_p     = 8'(bus.mul_a) * 8'(bus.mul_b);
        assign bus.sum_in    = 16'(adder_model(int'(bus.pp_ll), int'(bus.pp_lh),
                                               int'(bus.pp_hl), int'(bus.pp_hh)));

        approx_mul8_seq_ctrl #(
            .SKIP_ZERO (Skip)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        initial begin : mon
            int unsigned t_acc;
            int unsigned n_exp;
            int unsigned n_seen;
            logic [7:0]  m_a;
            logic [7:0]  m_b;
            bit          inflight;
            bit          seen_valid;
            bit          have_last;
            int          s;
            inflight = 1'b0;
            have_last = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    inflight  = 1'b0;
                    have_last = 1'b0;
                end else begin
                    if (bus.mul_en) begin
                        check_eq($sformatf("d%0d_mul_en_in_op", g),
                                 32'(inflight && n_seen < n_exp), 32'd1);
                        if (inflight && n_seen < n_exp) begin
                            s = kth_slot(Skip, m_a, m_b, int'(n_seen));
                            check_eq($sformatf("d%0d_mul_a", g), 32'(bus.mul_a),
                                     32'(nib_of(m_a, s >= 2)));
                            check_eq($sformatf("d%0d_mul_b", g), 32'(bus.mul_b),
                                     32'(nib_of(m_b, s % 2 == 1)));
                        end
                        n_seen++;
                    end
                    if (bus.out_valid) begin
                        check_eq($sformatf("d%0d_out_valid_in_op", g), 32'(inflight), 32'd1);
                        if (inflight && !seen_valid) begin
                            seen_valid = 1'b1;
                            check_eq($sformatf("d%0d_latency", g), cyc - t_acc, n_exp + 2);
                        end
                    end
                    if (inflight && bus.out_valid && bus.out_ready) begin
                        check_eq($sformatf("d%0d_result", g), 32'(bus.out_result),
                                 32'(model_result(m_a, m_b)));
                        check_eq($sformatf("d%0d_pp_ll", g), 32'(bus.pp_ll),
                                 32'(slot_prod(m_a, m_b, 0)));
                        check_eq($sformatf("d%0d_pp_lh", g), 32'(bus.pp_lh),
                                 32'(slot_prod(m_a, m_b, 1)));
                        check_eq($sformatf("d%0d_pp_hl", g), 32'(bus.pp_hl),
                                 32'(slot_prod(m_a, m_b, 2)));
                        check_eq($sformatf("d%0d_pp_hh", g), 32'(bus.pp_hh),
                                 32'(slot_prod(m_a, m_b, 3)));
                        check_eq($sformatf("d%0d_mul_cycles", g), n_seen, n_exp);
                        inflight = 1'b0;
                        if (bb_mode) done_cnt++;
                    end
                    if (bus.in_valid && bus.in_ready) begin
                        check_eq($sformatf("d%0d_accept_when_free", g), 32'(inflight), 32'd0);
                        if (bb_mode && have_last) begin
                            check_eq($sformatf("d%0d_issue_interval", g), cyc - t_acc, n_exp + 3);
                        end
                        m_a        = bus.in_a;
                        m_b        = bus.in_b;
                        n_exp      = 32'(n_mul(Skip, m_a, m_b));
                        n_seen     = 0;
                        t_acc      = cyc;
                        inflight   = 1'b1;
                        seen_valid = 1'b0;
                        have_last  = bb_mode;
                    end
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check_eq({tag, "_d0_in_ready"}, 32'(g_dut[0].bus.in_ready), 32'd1);
        check_eq({tag, "_d1_in_ready"}, 32'(g_dut[1].bus.in_ready), 32'd1);
        check_eq({tag, "_busy"}, 32'({g_dut[0].bus.busy, g_dut[1].bus.busy}), 32'd0);
        check_eq({tag, "_out_valid"}, 32'({g_dut[0].bus.out_valid, g_dut[1].bus.out_valid}), 32'd0);
        check_eq({tag, "_mul_en"}, 32'({g_dut[0].bus.mul_en, g_dut[1].bus.mul_en}), 32'd0);
        check_eq({tag, "_mul_ab"}, 32'({g_dut[0].bus.mul_a, g_dut[0].bus.mul_b,
                                        g_dut[1].bus.mul_a, g_dut[1].bus.mul_b}), 32'd0);
        check_eq({tag, "_d0_pp"}, {g_dut[0].bus.pp_ll, g_dut[0].bus.pp_lh,
                                   g_dut[0].bus.pp_hl, g_dut[0].bus.pp_hh}, 32'd0);
        check_eq({tag, "_d1_pp"}, {g_dut[1].bus.pp_ll, g_dut[1].bus.pp_lh,
                                   g_dut[1].bus.pp_hl, g_dut[1].bus.pp_hh}, 32'd0);
        check_eq({tag, "_result"}, {g_dut[0].bus.out_result, g_dut[1].bus.out_result}, 32'd0);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        d_in_valid = 1'b1;
        d_in_a     = a;
        d_in_b     = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = g_dut[0].bus.in_ready && g_dut[1].bus.in_ready;
        end
        check_eq("issue_ready", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = !g_dut[0].bus.busy && !g_dut[1].bus.busy;
        end
        check_eq("idle_reached", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        logic [7:0] ra;
        logic [7:0] rb;
        rst         = 1'b1;
        d_in_valid  = 1'b0;
        d_in_a      = '0;
        d_in_b      = '0;
        d_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        issue(8'hB7, 8'h5C);
        wait_idle();
        check_eq("b7x5c_d0_pp", {g_dut[0].bus.pp_ll, g_dut[0].bus.pp_lh,
                                 g_dut[0].bus.pp_hl, g_dut[0].bus.pp_hh}, 32'h5423_8437);
        check_eq("b7x5c_d0_result", 32'(g_dut[0].bus.out_result),
                 32'(adder_model(32'h54, 32'h23, 32'h84, 32'h37)));

        issue(8'h30, 8'h07);
        wait_idle();
        check_eq("30x07_d1_pp", {g_dut[1].bus.pp_ll, g_dut[1].bus.pp_lh,
                                 g_dut[1].bus.pp_hl, g_dut[1].bus.pp_hh}, 32'h0000_1500);

        issue(8'h00, 8'hFF);
        wait_idle();
        check_eq("00xff_d1_pp", {g_dut[1].bus.pp_ll, g_dut[1].bus.pp_lh,
                                 g_dut[1].bus.pp_hl, g_dut[1].bus.pp_hh}, 32'd0);
        check_eq("00xff_d1_result", 32'(g_dut[1].bus.out_result), 32'd0);

        // Stall in OUT with new operands presented; they must not be taken.
        d_out_ready = 1'b0;
        issue(8'h9A, 8'h3C);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = g_dut[0].bus.out_valid && g_dut[1].bus.out_valid;
        end
        check_eq("stall_out_valid", 32'(ok), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            d_in_valid = 1'b1;
            d_in_a     = 8'($urandom);
            d_in_b     = 8'($urandom);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ra = (k == 0) ? 8'(g_dut[0].bus.out_result) : 8'(g_dut[1].bus.out_result);
                rb = (k == 0) ? 8'(g_dut[0].bus.out_result >> 8) : 8'(g_dut[1].bus.out_result >> 8);
                check_eq($sformatf("stall_d%0d_result", k), 32'({rb, ra}),
                         32'(model_result(8'h9A, 8'h3C)));
            end
            check_eq("stall_in_ready", 32'({g_dut[0].bus.in_ready, g_dut[1].bus.in_ready}), 32'd0);
            check_eq("stall_out_valid_held",
                     32'({g_dut[0].bus.out_valid, g_dut[1].bus.out_valid}), 32'd3);
        end
        @(posedge clk);
        #1;
        d_in_a      = 8'h21;
        d_in_b      = 8'h43;
        d_out_ready = 1'b1;
        @(posedge clk);
        #1 d_out_ready = 1'b0;
        @(negedge clk);
        check_eq("after_stall_in_ready",
                 32'({g_dut[0].bus.in_ready, g_dut[1].bus.in_ready}), 32'd3);
        @(posedge clk);
        #1;
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        wait_idle();

        // Reset in the second multiplier cycle abandons the operation.
        issue(8'hFF, 8'hFF);
        @(posedge clk);
        #1;
        check_eq("mid_op_mul_en", 32'({g_dut[0].bus.mul_en, g_dut[1].bus.mul_en}), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("mid_op_reset");
        issue(8'h12, 8'h34);
        wait_idle();
        check_eq("12x34_d0_pp", {g_dut[0].bus.pp_ll, g_dut[0].bus.pp_lh,
                                 g_dut[0].bus.pp_hl, g_dut[0].bus.pp_hh}, 32'h0806_0403);
        check_eq("12x34_d1_pp", {g_dut[1].bus.pp_ll, g_dut[1].bus.pp_lh,
                                 g_dut[1].bus.pp_hl, g_dut[1].bus.pp_hh}, 32'h0806_0403);

        // Back-to-back random traffic with both handshakes always asserted.
        bb_mode     = 1'b1;
        d_out_ready = 1'b1;
        ok          = 1'b0;
        @(posedge clk);
        #1 d_in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            d_in_a = rnd_byte();
            d_in_b = rnd_byte();
            @(posedge clk);
            #1;
            ok = g_dut[0].done_cnt >= 16 && g_dut[1].done_cnt >= 16;
        end
        check_eq("b2b_completed", 32'(ok), 32'd1);
        d_in_valid = 1'b0;
        bb_mode    = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
